// File: rtl/spi_slave_if.sv
// Serial-side and memory-side signal bundle for spi_slave.
// The slave modport is the block's view; master is the driving side.
interface spi_slave_if;
  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;

  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave: assembles 10-bit {opcode, payload} frames from MOSI and returns
// one read byte on MISO per read-data frame.
module spi_slave (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  localparam int unsigned FRAME_W   = 10;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned TX_CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [FRAME_W-2:0]   shift_reg, shift_nxt;
  logic                 frame_done, frame_done_nxt;
  logic                 rd_addr_ok, rd_addr_ok_nxt;
  logic [DATA_W-1:0]    tx_shift, tx_shift_nxt;
  logic [TX_CNT_W-1:0]  tx_cnt, tx_cnt_nxt;
  logic                 tx_active, tx_active_nxt;
  logic                 tx_sent, tx_sent_nxt;
  logic [FRAME_W-1:0]   rx_data_nxt;
  logic                 rx_valid_nxt;
  logic                 miso_nxt;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      frame_done   <= 1'b0;
      rd_addr_ok   <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      tx_active    <= 1'b0;
      tx_sent      <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.MISO     <= 1'b0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift_reg    <= shift_nxt;
      frame_done   <= frame_done_nxt;
      rd_addr_ok   <= rd_addr_ok_nxt;
      tx_shift     <= tx_shift_nxt;
      tx_cnt       <= tx_cnt_nxt;
      tx_active    <= tx_active_nxt;
      tx_sent      <= tx_sent_nxt;
      bus.rx_data  <= rx_data_nxt;
      bus.rx_valid <= rx_valid_nxt;
      bus.MISO     <= miso_nxt;
    end
  end

  // Next-state and output logic; MISO is low unless a byte is being shifted
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift_reg;
    frame_done_nxt = frame_done;
    rd_addr_ok_nxt = rd_addr_ok;
    tx_shift_nxt   = tx_shift;
    tx_cnt_nxt     = tx_cnt;
    tx_active_nxt  = tx_active;
    tx_sent_nxt    = tx_sent;
    rx_data_nxt    = bus.rx_data;
    rx_valid_nxt   = 1'b0;
    miso_nxt       = 1'b0;

    if (state != IDLE && bus.SS_n) begin
      state_nxt      = IDLE;
      bit_cnt_nxt    = '0;
      tx_cnt_nxt     = '0;
      frame_done_nxt = 1'b0;
      tx_active_nxt  = 1'b0;
      tx_sent_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt_nxt    = '0;
          tx_cnt_nxt     = '0;
          frame_done_nxt = 1'b0;
          tx_active_nxt  = 1'b0;
          tx_sent_nxt    = 1'b0;
          if (!bus.SS_n) state_nxt = CHK_CMD;
        end

        CHK_CMD: begin
          shift_nxt      = {8'h00, bus.MOSI};
          bit_cnt_nxt    = BIT_CNT_W'(FRAME_W - 2);
          frame_done_nxt = 1'b0;
          if (!bus.MOSI)       state_nxt = WRITE;
          else if (rd_addr_ok) state_nxt = READ_DATA;
          else                 state_nxt = READ_ADD;
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (!frame_done) begin
            shift_nxt = {shift_reg[FRAME_W-3:0], bus.MOSI};
            if (bit_cnt == '0) begin
              rx_data_nxt    = {shift_reg, bus.MOSI};
              rx_valid_nxt   = 1'b1;
              frame_done_nxt = 1'b1;
              if (state == READ_ADD)       rd_addr_ok_nxt = 1'b1;
              else if (state == READ_DATA) rd_addr_ok_nxt = 1'b0;
            end else begin
              bit_cnt_nxt = bit_cnt - BIT_CNT_W'(1);
            end
          end else if (state == READ_DATA) begin
            // One byte per frame: latch once, shift MSB first, then go quiet
            if (tx_active) begin
              if (tx_cnt != '0) begin
                miso_nxt     = tx_shift[DATA_W-1];
                tx_shift_nxt = {tx_shift[DATA_W-2:0], 1'b0};
                tx_cnt_nxt   = tx_cnt - TX_CNT_W'(1);
              end else begin
                tx_active_nxt = 1'b0;
                tx_sent_nxt   = 1'b1;
              end
            end else if (!tx_sent && bus.tx_valid) begin
              miso_nxt      = bus.tx_data[DATA_W-1];
              tx_shift_nxt  = {bus.tx_data[DATA_W-2:0], 1'b0};
              tx_cnt_nxt    = TX_CNT_W'(DATA_W - 1);
              tx_active_nxt = 1'b1;
            end
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: frames are queued as expectations by the
// stimulus and checked by an independent rx_valid monitor.
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst = 1'b0;

  spi_slave_if bus ();

  spi_slave dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] data;
    int         at;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] last_rx = 10'h000;
  logic       prev_valid = 1'b0;

  localparam logic [31:0] ST_IDLE      = 32'd0;
  localparam logic [31:0] ST_WRITE     = 32'd2;
  localparam logic [31:0] ST_READ_ADD  = 32'd3;
  localparam logic [31:0] ST_READ_DATA = 32'd4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every rx_valid strobe must match the oldest pending frame
  always @(negedge clk) begin
    exp_t e;
    if (bus.rx_valid === 1'b1) begin
      check("rx_valid_width", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_unexpected: got rx_data %0h, expected no strobe", bus.rx_data);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", 32'(bus.rx_data), 32'(e.data));
        check("rx_valid_cycle", 32'(cyc), 32'(e.at));
        last_rx = e.data;
      end
    end
    prev_valid = (bus.rx_valid === 1'b1);
  end

  // Drops SS_n and drives the first nbits of f; leaves SS_n low
  task automatic send_bits(input logic [9:0] f, input int nbits, input logic expect_done);
    int t0;
    @(negedge clk);
    bus.SS_n = 1'b0;
    t0 = cyc;
    if (expect_done) exp_q.push_back('{f, t0 + 11});
    for (int i = 9; i > 9 - nbits; i--) begin
      @(negedge clk);
      check("miso_idle_rx", 32'(bus.MISO), 32'd0);
      bus.MOSI = f[i];
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    @(negedge clk);
  endtask

  // Supplies tx data wait_cyc cycles after rx_valid and checks the MISO byte
  task automatic tx_byte(input logic [7:0] d, input int wait_cyc, input logic extra, input int rst_at);
    logic stop;
    stop = 1'b0;
    @(negedge clk);
    repeat (wait_cyc) begin
      check("miso_wait", 32'(bus.MISO), 32'd0);
      @(negedge clk);
    end
    check("miso_wait", 32'(bus.MISO), 32'd0);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (!stop) begin
        @(negedge clk);
        if (i == 7) bus.tx_valid = 1'b0;
        if (extra && i == 5) begin
          bus.tx_valid = 1'b1;
          bus.tx_data  = ~d;
        end
        if (extra && i == 4) bus.tx_valid = 1'b0;
        check("miso_bit", 32'(bus.MISO), 32'(d[i]));
        if (i == rst_at) begin
          #2 rst = 1'b1;
          #1;
          check("rst_miso", 32'(bus.MISO), 32'd0);
          check("rst_state", 32'(dut.state), ST_IDLE);
          check("rst_rd_addr_ok", 32'(dut.rd_addr_ok), 32'd0);
          check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
          check("rst_rx_data", 32'(bus.rx_data), 32'd0);
          stop = 1'b1;
        end
      end
    end
    if (!stop) begin
      @(negedge clk);
      check("miso_after", 32'(bus.MISO), 32'd0);
      if (extra) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
      end
      @(negedge clk);
      bus.tx_valid = 1'b0;
      repeat (3) begin
        check("miso_ignored", 32'(bus.MISO), 32'd0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("reset_miso", 32'(bus.MISO), 32'd0);
    check("reset_state", 32'(dut.state), ST_IDLE);
    check("reset_rd_addr_ok", 32'(dut.rd_addr_ok), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write frame; trailing MOSI activity must be ignored
    send_bits(10'h0A5, 10, 1'b1);
    @(negedge clk);
    bus.MOSI = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("write_hold_state", 32'(dut.state), ST_WRITE);
      check("write_miso", 32'(bus.MISO), 32'd0);
    end
    end_frame();
    check("write_rd_addr_ok", 32'(dut.rd_addr_ok), 32'd0);

    // Read address then read data
    send_bits(10'h2F0, 10, 1'b1);
    end_frame();
    check("rdaddr_rd_addr_ok", 32'(dut.rd_addr_ok), 32'd1);
    send_bits(10'h300, 10, 1'b1);
    check("rddata_state", 32'(dut.state), ST_READ_DATA);
    tx_byte(8'hC3, 0, 1'b0, -1);
    end_frame();
    check("rddata_rd_addr_ok", 32'(dut.rd_addr_ok), 32'd0);

    // Read without address goes to READ_ADD
    send_bits(10'h311, 10, 1'b1);
    check("noaddr_state", 32'(dut.state), ST_READ_ADD);
    @(negedge clk);
    end_frame();
    check("noaddr_rd_addr_ok", 32'(dut.rd_addr_ok), 32'd1);

    // Late tx_valid plus extra pulses during and after the shift
    send_bits(10'h3AA, 10, 1'b1);
    check("late_state", 32'(dut.state), ST_READ_DATA);
    tx_byte(8'h5A, 6, 1'b1, -1);
    end_frame();
    check("late_rd_addr_ok", 32'(dut.rd_addr_ok), 32'd0);

    // Abort after 5 bits, then a full frame
    send_bits(10'h1FF, 5, 1'b0);
    end_frame();
    check("abort_rx_data", 32'(bus.rx_data), 32'(last_rx));
    check("abort_state", 32'(dut.state), ST_IDLE);
    send_bits(10'h07F, 10, 1'b1);
    end_frame();

    // Async reset during the 4th MISO bit
    send_bits(10'h2AB, 10, 1'b1);
    end_frame();
    send_bits(10'h3CD, 10, 1'b1);
    tx_byte(8'h96, 2, 1'b0, 4);
    @(negedge clk);
    rst          = 1'b0;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    last_rx      = 10'h000;
    @(negedge clk);
    check("post_rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("post_rst_state", 32'(dut.state), ST_IDLE);

    // First frame after reset
    send_bits(10'h0C3, 10, 1'b1);
    end_frame();
    check("recover_rd_addr_ok", 32'(dut.rd_addr_ok), 32'd0);

    repeat (3) @(negedge clk);
    check("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
